// File: rtl/base58_pkg.sv
// Shared Base58 constants, alphabet lookup and FSM state type for the stream encoder.
package base58_pkg;

  localparam int RADIX = 58;
  localparam int REM_W = 6;

  localparam logic [8*RADIX-1:0] ALPHABET =
    "123456789ABCDEFGHJKLMNPQRSTUVWXYZabcdefghijkmnopqrstuvwxyz";

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Digit 0 is the leftmost character of the string, which sits in the top byte.
  function automatic logic [7:0] b58_char(input logic [REM_W-1:0] digit);
    logic [7:0] ch;
    ch = 8'h00;
    if (int'(digit) < RADIX) ch = ALPHABET[8*(RADIX-1-int'(digit)) +: 8];
    return ch;
  endfunction

  // Number of base-58 digits needed for the largest value of a given bit width.
  function automatic int min_digits(input int width);
    logic [63:0] v;
    int n;
    v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    n = 0;
    do begin
      v = v / 64'(RADIX);
      n++;
    end while (v != 64'd0);
    return n;
  endfunction

endpackage

// File: rtl/base58_div_step.sv
// One restoring-division step by 58: shifts the quotient MSB into the remainder.
module base58_div_step
  import base58_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]     quot,
  input  logic [REM_W-1:0] rem,
  output logic [W-1:0]     quot_next,
  output logic [REM_W-1:0] rem_next
);

  localparam logic [REM_W:0] DIVISOR = (REM_W+1)'(RADIX);

  logic [REM_W:0] trial;
  logic [REM_W:0] diff;
  logic           fits;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    trial     = {rem, quot[W-1]};
    diff      = trial - DIVISOR;
    fits      = (trial >= DIVISOR);
    rem_next  = fits ? diff[REM_W-1:0] : trial[REM_W-1:0];
    quot_next = {quot[W-2:0], fits};
  end

endmodule

// File: rtl/base58_stream_encoder.sv
// Streams an unsigned binary value as Base58 ASCII, most significant digit first.
module base58_stream_encoder
  import base58_pkg::*;
#(
  parameter int IN_WIDTH   = 32,
  parameter int MAX_DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_pad,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_char,
  output logic                out_last,
  output logic                busy
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int BIT_W = $clog2(IN_WIDTH);

  if (IN_WIDTH < 8 || IN_WIDTH > 64) begin : g_bad_width
    $error("base58_stream_encoder: IN_WIDTH must be within 8..64");
  end
  if (MAX_DIGITS < min_digits(IN_WIDTH)) begin : g_bad_depth
    $error("base58_stream_encoder: MAX_DIGITS too small for IN_WIDTH");
  end

  state_e              state;
  logic [IN_WIDTH-1:0] quot;
  logic [IN_WIDTH-1:0] quot_next;
  logic [REM_W-1:0]    rem;
  logic [REM_W-1:0]    rem_next;
  logic [BIT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_inc;
  logic [CNT_W-1:0]    index;
  logic                pad;
  logic                digit_done;
  logic                more_digits;
  logic [REM_W-1:0]    digit_buf [MAX_DIGITS];

  base58_div_step #(.W(IN_WIDTH)) u_div_step (
    .quot      (quot),
    .rem       (rem),
    .quot_next (quot_next),
    .rem_next  (rem_next)
  );

  assign digit_done  = (bit_cnt == BIT_W'(IN_WIDTH - 1));
  assign count_inc   = count + CNT_W'(1);
  // Padding keeps dividing the (now zero) quotient, producing leading '1' digits.
  assign more_digits = (quot_next != '0) || (pad && (count_inc < CNT_W'(MAX_DIGITS)));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      quot    <= '0;
      rem     <= '0;
      bit_cnt <= '0;
      count   <= '0;
      index   <= '0;
      pad     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            quot    <= in_data;
            pad     <= in_pad;
            rem     <= '0;
            bit_cnt <= '0;
            count   <= '0;
            state   <= ST_DIV;
          end
        end
        ST_DIV: begin
          quot <= quot_next;
          if (digit_done) begin
            count   <= count_inc;
            rem     <= '0;
            bit_cnt <= '0;
            if (!more_digits) begin
              index <= count;
              state <= ST_EMIT;
            end
          end else begin
            rem     <= rem_next;
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (index == '0) state <= ST_IDLE;
            else             index <= index - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the digit buffer is plain storage with no reset; count/index guard every read.
  always_ff @(posedge clk) begin
    if (state == ST_DIV && digit_done) digit_buf[count] <= rem_next;
  end

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_EMIT);
  assign out_last  = out_valid && (index == '0);
  assign out_char  = out_valid ? b58_char(digit_buf[index]) : 8'h00;

endmodule

// File: tb/tb_base58_stream_encoder.sv
// Self-checking bench: reference Base58 model feeds a character scoreboard.
module tb_base58_stream_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        in_pad = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_char;
  logic        out_last;
  logic        busy;

  typedef struct {
    logic [7:0] ch;
    logic       last;
  } exp_t;

  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;
  int    pops = 0;
  string rx = "";
  string alph = "123456789ABCDEFGHJKLMNPQRSTUVWXYZabcdefghijkmnopqrstuvwxyz";

  logic       prev_stall = 1'b0;
  logic [7:0] prev_char = 8'h00;
  logic       prev_last = 1'b0;

  base58_stream_encoder #(.IN_WIDTH(32), .MAX_DIGITS(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pad    (in_pad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
    end
  endtask

  function automatic string model(input logic [31:0] v, input logic pad);
    string       s;
    int          n;
    logic [31:0] q;
    s = "";
    n = 0;
    q = v;
    do begin
      s = $sformatf("%c%s", alph[int'(q % 32'd58)], s);
      q = q / 32'd58;
      n++;
    end while (q != 32'd0);
    if (pad) while (n < 6) begin
      s = $sformatf("1%s", s);
      n++;
    end
    return s;
  endfunction

  task automatic push_exp(input string s);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.ch   = s[i];
      e.last = (i == s.len() - 1);
      sb.push_back(e);
    end
  endtask

  // Output monitor: hold-stability while stalled, scoreboard compare on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (prev_stall && out_valid === 1'b1) begin
      check("hold_char", out_char, prev_char);
      check("hold_last", out_last, prev_last);
    end
    prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
    prev_char  = out_char;
    prev_last  = out_last;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("extra_char", out_char, 8'h00);
      end else begin
        e = sb.pop_front();
        check("char", out_char, e.ch);
        check("last", out_last, e.last);
      end
      rx = $sformatf("%s%c", rx, out_char);
      pops++;
    end
  end

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic send(input logic [31:0] d, input logic p);
    int b;
    b = 0;
    while (in_ready !== 1'b1 && b < 2000) begin
      @(posedge clk); #1;
      b++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    in_pad   = p;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit toggle);
    int b;
    b = 0;
    while ((sb.size() != 0 || in_ready !== 1'b1) && b < budget) begin
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
      b++;
    end
    out_ready = 1'b1;
    check("drain_in_budget", b < budget, 1'b1);
    check("scoreboard_empty", sb.size(), 0);
  endtask

  task automatic run(input logic [31:0] d, input logic p, input bit toggle, input string exp_str);
    string m;
    int    n;
    m  = model(d, p);
    rx = "";
    push_exp(m);
    send(d, p);
    n = 0;
    while (out_valid !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, m.len() * 32);
    wait_drain(2000, toggle);
    check_str("string", rx, exp_str);
  endtask

  initial begin
    int    n;
    int    p0;
    string both;

    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_char", out_char, 8'h00);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1'b1);

    run(32'd123, 1'b0, 1'b0, "38");
    run(32'd0, 1'b0, 1'b0, "1");
    run(32'd0, 1'b1, 1'b0, "111111");
    run(32'hFFFF_FFFF, 1'b0, 1'b0, "7YXq9G");
    run(32'd58, 1'b0, 1'b0, "21");
    run(32'd57, 1'b0, 1'b0, "z");
    run(32'd123, 1'b1, 1'b1, "111138");

    // Reset in EMIT after the first character has been taken.
    rx = "";
    push_exp(model(32'hFFFF_FFFF, 1'b0));
    send(32'hFFFF_FFFF, 1'b0);
    p0 = pops;
    n  = 0;
    while (pops == p0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_char_seen", pops - p0, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_char", out_char, 8'h00);
    check("midrst_out_last", out_last, 1'b0);
    check("midrst_busy", busy, 1'b0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_in_ready", in_ready, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("postrst_no_char", out_valid, 1'b0);
    check_str("aborted_string", rx, "7");
    run(32'd128, 1'b0, 1'b0, model(32'd128, 1'b0));

    // Back-to-back values with in_valid held high throughout.
    rx   = "";
    both = {model(32'd245, 1'b0), model(32'd12, 1'b0)};
    push_exp(model(32'd245, 1'b0));
    push_exp(model(32'd12, 1'b0));
    in_valid = 1'b1;
    in_data  = 32'd245;
    in_pad   = 1'b0;
    @(posedge clk); #1;
    in_data = 32'd12;
    check("b2b_first_busy", busy, 1'b1);
    n = 0;
    while (!(out_valid === 1'b1 && out_last === 1'b1) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_last_seen", out_last, 1'b1);
    @(posedge clk); #1;
    check("b2b_in_ready_after_last", in_ready, 1'b1);
    @(posedge clk); #1;
    check("b2b_second_accepted", busy, 1'b1);
    in_valid = 1'b0;
    wait_drain(2000, 1'b0);
    check_str("b2b_string", rx, both);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
